nt_level_scheduler: RTL and testbench
=====================================

Name: nt_level_scheduler

Overview:
- Shares one neurotransmitter level register among NREQ stimulus requesters.
- Each cycle it selects at most one command and drives the level register's inc/dec/fast/setval strobes, so simultaneous stimuli never collide.
- Adds homeostatic decay: a periodic one-step nudge of the level toward BASELINE.
- Sits between the emotion/stimulus logic and the level register; the level register's value is fed back as `level`.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 8, level width (must match level register)
- DECAY_PERIOD, 16, cycles between decay opportunities (>=2)
- BASELINE, 2, decay target value (< 2^N)
- IDW, 2, grant_id width (= ceil(log2(NREQ)), minimum 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command pending
- req_dir  in  NREQ  1 = increment, 0 = decrement
- req_fast  in  NREQ  1 = fast step
- req_ready  out  NREQ  combinational grant; a transfer occurs when valid&ready at a rising edge
- flush  in  1  request reset of level to its SET_VAL
- level  in  N  current level-register value
- inc  out  1  registered one-cycle strobe to level register
- dec  out  1  registered one-cycle strobe
- fast  out  1  registered, qualifies inc/dec
- setval  out  1  registered one-cycle strobe
- grant_id  out  IDW  registered index of last granted requester
- decay_evt  out  1  registered pulse: the command just issued is a decay step

Behaviour:
- Reset: inc, dec, fast, setval, decay_evt = 0; grant_id = 0; round-robin pointer rr = 0; decay counter dcnt = DECAY_PERIOD-1; decay_pending = 0; settle = 0.
- Priority each cycle: flush > requester > decay. At most one command is registered per edge.
- Flush: all req_ready = 0 in that cycle. At the edge:
  - setval <= 1, inc/dec/fast <= 0.
  - dcnt reloads to DECAY_PERIOD-1; decay_pending <= 0.
  - rr is unchanged.
- Arbitration (flush = 0): search from index rr upward with wrap; the first i with req_valid[i] gets req_ready[i] = 1, all others 0. At the transfer edge:
  - inc <= req_dir[i], dec <= ~req_dir[i], fast <= req_fast[i].
  - grant_id <= i; rr <= (i+1) mod NREQ.
- Requester commands may issue on back-to-back cycles. Latency: strobe is high exactly one cycle after the transfer edge.
- Decay counter: dcnt decrements every cycle, including during flush-free request cycles. On reaching 0 it reloads DECAY_PERIOD-1 and sets decay_pending. If decay_pending is already set it stays set; events do not accumulate.
- Decay issue: when flush = 0, no req_valid, decay_pending = 1 and settle = 0, compare `level` with BASELINE:
  - level > BASELINE: dec <= 1, fast <= 0, decay_evt <= 1.
  - level < BASELINE: inc <= 1, fast <= 0, decay_evt <= 1.
  - level == BASELINE: no strobe.
  - In all three cases decay_pending <= 0.
- settle: set to 1 for one cycle after any inc/dec/setval issue, because `level` reflects a command two edges later. Decay is blocked while settle = 1; requester traffic is not.
- Idle cycles: all strobes 0. inc and dec are never both 1; setval is never concurrent with inc/dec.
- Saturation at 0 / 2^N-1 belongs to the level register; the scheduler does not check it.
- Reset asserted mid-operation returns everything to reset values immediately; a pending grant is lost and the requester re-presents it.
- When req_valid drops without a grant, nothing is issued for it.

Test Plan:
- Reset, no stimulus, level held at 5: decay pulses appear on dec with decay_evt at DECAY_PERIOD intervals (first strobe at cycle 16). With level = 2, no strobes.
- req_valid = 4'b1111, all dir = 1, held for 8 cycles: grants cycle 0,1,2,3,0,1,2,3; inc high for 8 consecutive cycles, each one cycle after its transfer; grant_id follows.
- Requesters 1 (dir = 0, fast = 1) and 3 (dir = 1) valid with rr = 2: requester 3 granted first (inc = 1, fast = 0), then requester 1 (dec = 1, fast = 1).
- flush with req_valid = 4'b0011 present: req_ready = 0 that cycle, setval pulses once, dcnt restarts (next decay 16 cycles later). The following cycle grants requester 0.
- Decay pending while requester traffic continues for 20 cycles: no decay issued. At the first idle cycle not in settle, decay issues once based on the current level; a second period elapsing meanwhile does not produce a double step.
- Assert rst_n low for one cycle while req_ready[2] = 1: all outputs 0 and rr = 0 after reset; requester 2 is re-granted only after re-presenting.

Source files
------------

// File: rtl/nt_level_scheduler.sv
// Arbitrates requester stimuli, flush and homeostatic decay onto the single
// inc/dec/fast/setval strobe set of a shared neurotransmitter level register.
module nt_level_scheduler #(
  parameter int NREQ         = 4,
  parameter int N            = 8,
  parameter int DECAY_PERIOD = 16,
  parameter int BASELINE     = 2,
  parameter int IDW          = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_dir,
  input  logic [NREQ-1:0] req_fast,
  output logic [NREQ-1:0] req_ready,
  input  logic            flush,
  input  logic [N-1:0]    level,
  output logic            inc,
  output logic            dec,
  output logic            fast,
  output logic            setval,
  output logic [IDW-1:0]  grant_id,
  output logic            decay_evt
);

  localparam int DCW = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DCW-1:0] DCNT_RELOAD = DCW'(DECAY_PERIOD - 1);
  localparam logic [N-1:0]   BASE_LVL    = N'(BASELINE);
  localparam logic [IDW-1:0] LAST_IDX    = IDW'(NREQ - 1);

  logic [IDW-1:0] rr;
  logic [DCW-1:0] dcnt;
  logic           decay_pending;
  logic           settle;

  logic           gnt_hit_p0;
  logic [IDW-1:0] gnt_idx_p0;
  logic           decay_go_p0;
  logic           lvl_hi_p0;
  logic           lvl_lo_p0;

  // Stage p0: rotating-priority search starting at rr, plus decay decision
  always_comb begin
    gnt_hit_p0 = 1'b0;
    gnt_idx_p0 = '0;
    req_ready  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_hit_p0 && req_valid[j]) begin
        gnt_hit_p0 = 1'b1;
        gnt_idx_p0 = IDW'(j);
      end
    end
    if (!flush && gnt_hit_p0) req_ready[gnt_idx_p0] = 1'b1;
  end

  assign decay_go_p0 = !flush && !gnt_hit_p0 && decay_pending && !settle;
  assign lvl_hi_p0   = level > BASE_LVL;
  assign lvl_lo_p0   = level < BASE_LVL;

  // Stage p1: registered strobes towards the level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc       <= 1'b0;
      dec       <= 1'b0;
      fast      <= 1'b0;
      setval    <= 1'b0;
      decay_evt <= 1'b0;
      grant_id  <= '0;
      rr        <= '0;
      settle    <= 1'b0;
    end else begin
      inc       <= 1'b0;
      dec       <= 1'b0;
      fast      <= 1'b0;
      setval    <= 1'b0;
      decay_evt <= 1'b0;
      settle    <= 1'b0;
      if (flush) begin
        setval <= 1'b1;
        settle <= 1'b1;
      end else if (gnt_hit_p0) begin
        inc      <= req_dir[gnt_idx_p0];
        dec      <= ~req_dir[gnt_idx_p0];
        fast     <= req_fast[gnt_idx_p0];
        grant_id <= gnt_idx_p0;
        rr       <= (gnt_idx_p0 == LAST_IDX) ? '0 : gnt_idx_p0 + 1'b1;
        settle   <= 1'b1;
      end else if (decay_go_p0) begin
        // level already at baseline: the pending step is consumed silently
        if (lvl_hi_p0) begin
          dec       <= 1'b1;
          decay_evt <= 1'b1;
          settle    <= 1'b1;
        end else if (lvl_lo_p0) begin
          inc       <= 1'b1;
          decay_evt <= 1'b1;
          settle    <= 1'b1;
        end
      end
    end
  end

  // Decay timebase; a new period landing on an issue edge re-arms the step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt          <= DCNT_RELOAD;
      decay_pending <= 1'b0;
    end else if (flush) begin
      dcnt          <= DCNT_RELOAD;
      decay_pending <= 1'b0;
    end else if (dcnt == '0) begin
      dcnt          <= DCNT_RELOAD;
      decay_pending <= 1'b1;
    end else begin
      dcnt <= dcnt - 1'b1;
      if (decay_go_p0) decay_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nt_level_scheduler.sv
// Directed bench for nt_level_scheduler: decay timing, round-robin order,
// flush priority, decay deferral under traffic and mid-operation reset.
module tb_nt_level_scheduler;
  localparam int NREQ = 4;
  localparam int N    = 8;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_dir = '0;
  logic [NREQ-1:0] req_fast = '0;
  logic            flush = 1'b0;
  logic [N-1:0]    level = 8'd5;
  logic [NREQ-1:0] req_ready;
  logic            inc, dec, fast, setval, decay_evt;
  logic [IDW-1:0]  grant_id;

  int n_chk = 0;
  int n_fail = 0;

  nt_level_scheduler #(
    .NREQ(NREQ), .N(N), .DECAY_PERIOD(16), .BASELINE(2), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dir(req_dir), .req_fast(req_fast),
    .req_ready(req_ready), .flush(flush), .level(level),
    .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .grant_id(grant_id), .decay_evt(decay_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until decay_evt is seen; n is the number of edges taken (bounded)
  task automatic wait_evt(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!decay_evt && n < bound);
  endtask

  int n, cnt, cnt_inc;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_fast", fast, 0);
    check("rst_setval", setval, 0);
    check("rst_decay_evt", decay_evt, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready", req_ready, 0);
    rst_n = 1'b1;

    // Decay toward baseline from level 5: first step 17 edges after release
    wait_evt(40, n);
    check("decay_first_edges", n, 17);
    check("decay_first_dec", dec, 1);
    check("decay_first_inc", inc, 0);
    check("decay_first_fast", fast, 0);
    wait_evt(40, n);
    check("decay_period", n, 16);
    check("decay_second_dec", dec, 1);

    // Level at baseline: no strobes at all
    level = 8'd2;
    cnt = 0;
    repeat (40) begin
      tick();
      if (inc || dec || setval || decay_evt) cnt++;
    end
    check("baseline_no_strobe", cnt, 0);

    // All four requesters incrementing: strict rotation 0..3,0..3
    req_valid = 4'hF;
    req_dir   = 4'hF;
    req_fast  = 4'h0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", req_ready, 32'(1 << (k % 4)));
      tick();
      check("rr_inc", inc, 1);
      check("rr_dec", dec, 0);
      check("rr_grant_id", grant_id, k % 4);
    end
    req_valid = 4'h0;
    tick();
    check("idle_inc", inc, 0);

    // Move rr to 2 by granting requester 1 alone
    req_valid = 4'b0010;
    req_dir   = 4'b0010;
    tick();
    req_valid = 4'b1010;
    req_dir   = 4'b1000;
    req_fast  = 4'b0010;
    #1;
    check("rr2_ready_first", req_ready, 4'b1000);
    tick();
    check("rr2_r3_inc", inc, 1);
    check("rr2_r3_dec", dec, 0);
    check("rr2_r3_fast", fast, 0);
    check("rr2_r3_id", grant_id, 3);
    #1;
    check("rr2_ready_second", req_ready, 4'b0010);
    tick();
    check("rr2_r1_dec", dec, 1);
    check("rr2_r1_inc", inc, 0);
    check("rr2_r1_fast", fast, 1);
    check("rr2_r1_id", grant_id, 1);
    req_valid = 4'h0;
    req_fast  = 4'h0;

    // Flush wins over pending requesters and restarts the decay timebase
    level     = 8'd5;
    req_valid = 4'b0011;
    req_dir   = 4'b0011;
    flush     = 1'b1;
    #1;
    check("flush_ready", req_ready, 0);
    tick();
    check("flush_setval", setval, 1);
    check("flush_inc", inc, 0);
    check("flush_dec", dec, 0);
    flush = 1'b0;
    #1;
    check("post_flush_ready", req_ready, 4'b0001);
    tick();
    check("post_flush_setval", setval, 0);
    check("post_flush_inc", inc, 1);
    check("post_flush_id", grant_id, 0);
    req_valid = 4'h0;
    wait_evt(40, n);
    check("flush_decay_edges", n + 1, 17);
    check("flush_decay_dec", dec, 1);

    // Traffic defers decay; two periods elapse yet only one step follows
    req_valid = 4'b0001;
    req_dir   = 4'b0001;
    cnt_inc = 0;
    cnt = 0;
    repeat (40) begin
      tick();
      if (inc) cnt_inc++;
      if (decay_evt) cnt++;
    end
    check("traffic_incs", cnt_inc, 40);
    check("traffic_no_decay", cnt, 0);
    req_valid = 4'h0;
    tick();
    check("settle_block_dec", dec, 0);
    tick();
    check("deferred_decay_dec", dec, 1);
    check("deferred_decay_evt", decay_evt, 1);
    cnt = 0;
    repeat (4) begin
      tick();
      if (decay_evt || inc || dec) cnt++;
    end
    check("no_double_step", cnt, 0);

    // Below baseline the decay step increments
    level = 8'd0;
    wait_evt(10, n);
    check("decay_up_edges", n, 2);
    check("decay_up_inc", inc, 1);
    check("decay_up_dec", dec, 0);

    // Asynchronous reset while requester 2 holds the grant
    level     = 8'd2;
    req_valid = 4'b0100;
    req_dir   = 4'b0100;
    #1;
    check("pre_rst_ready", req_ready, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inc", inc, 0);
    check("mid_rst_dec", dec, 0);
    check("mid_rst_decay_evt", decay_evt, 0);
    check("mid_rst_grant_id", grant_id, 0);
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_inc", inc, 0);
    check("post_rst_id", grant_id, 0);
    req_valid = 4'b0101;
    req_dir   = 4'b0101;
    #1;
    check("post_rst_ready_r0", req_ready, 4'b0001);
    tick();
    check("post_rst_r0_id", grant_id, 0);
    check("post_rst_r0_inc", inc, 1);
    #1;
    check("post_rst_ready_r2", req_ready, 4'b0100);
    tick();
    check("post_rst_r2_id", grant_id, 2);
    check("post_rst_r2_inc", inc, 1);
    req_valid = 4'h0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
